// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM encoding,
// majority-vote sample positions and the baud divisor calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } rx_state_t;

    function automatic int baud_div(input int clock_rate, input int baud_rate, input int oversample);
        return clock_rate / (baud_rate * oversample);
    endfunction

    // Three samples straddling mid-bit feed the majority vote.
    function automatic int vote_first(input int oversample);
        return oversample / 2 - 1;
    endfunction

    function automatic int vote_mid(input int oversample);
        return oversample / 2;
    endfunction

    function automatic int vote_last(input int oversample);
        return oversample / 2 + 1;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clk pulse every DIVISOR clocks,
// realigned to zero when a start edge is detected.
module uart_baud_tick #(
    parameter int DIVISOR = 78
) (
    input  logic clk,
    input  logic reset,
    input  logic i_restart,
    output logic o_tick
);
    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_restart || r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tick = (r_count == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised 16x-oversampling UART receiver with frame/parity/break detection.
// Define UART_RX_PARITY_EN to add a parity slot after the data bits.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxEn,
    input  logic                 rx,
    output logic                 rxBusy,
    output logic                 rxDone,
    output logic                 rxErr,
    output logic                 rxParErr,
    output logic                 rxBreak,
    output logic [DATA_BITS-1:0] out
);
    localparam int DIV = baud_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_MID    = SW'(vote_mid(OVERSAMPLE));
    localparam logic [SW-1:0] S_V0     = SW'(vote_first(OVERSAMPLE));
    localparam logic [SW-1:0] S_V2     = SW'(vote_last(OVERSAMPLE));
    localparam logic [SW-1:0] S_WIN_LO = SW'(2);
    localparam logic [SW-1:0] S_WIN_HI = SW'(OVERSAMPLE - 3);
    localparam logic [SW-1:0] S_TAIL   = SW'(OVERSAMPLE - 2);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    generate
        if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
            (STOP_BITS != 1 && STOP_BITS != 2) || (PARITY_ODD != 0 && PARITY_ODD != 1) ||
            DIV < 1) begin : g_bad_params
            $error("uart_rx_param: invalid parameter set");
        end
    endgenerate

    logic                 r_rx_meta, r_rx_sync, r_rx_prev;
    logic                 w_fall, w_tick, w_restart, w_bit_end, w_vote, w_start_ok;
    rx_state_t            r_state, w_state_next;
    logic [SW-1:0]        r_sample;
    logic [3:0]           r_bit_cnt;
    logic [1:0]           r_votes;
    logic [DATA_BITS-1:0] r_shift, r_out;
    logic                 r_stop_low, r_brk_wait, r_fall_pend;
    logic                 r_busy, r_done, r_err, r_brk;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bit, r_par_err;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_fall     = r_rx_prev & ~r_rx_sync;
    assign w_bit_end  = w_tick && (r_sample == S_LAST);
    assign w_vote     = maj3(r_votes[0], r_votes[1], r_rx_sync);
    assign w_start_ok = rxEn && (r_state == ST_START) && w_tick && (r_sample == S_MID) && !r_rx_sync;

    uart_baud_tick #(.DIVISOR(DIV)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_restart    = 1'b0;
        if (!rxEn) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fall && !r_brk_wait) begin
                        w_state_next = ST_START;
                        w_restart    = 1'b1;
                    end
                end
                ST_START: begin
                    if (w_tick && r_sample == S_MID && r_rx_sync) w_state_next = ST_IDLE;
                    else if (w_bit_end)                           w_state_next = ST_DATA;
                end
                ST_DATA: begin
                    if (w_bit_end && r_bit_cnt == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end
                end
                ST_PARITY: if (w_bit_end) w_state_next = ST_STOP;
                ST_STOP:   if (w_bit_end && r_bit_cnt == STOP_LAST) w_state_next = ST_DONE;
                ST_DONE: begin
                    // A start edge landing in the closing samples of the stop bit is remembered in r_fall_pend.
                    if (!r_brk_wait && (w_fall || (r_fall_pend && !r_rx_sync))) begin
                        w_state_next = ST_START;
                        w_restart    = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample    <= '0;
            r_bit_cnt   <= '0;
            r_votes     <= '0;
            r_shift     <= '0;
            r_out       <= '0;
            r_stop_low  <= 1'b0;
            r_brk_wait  <= 1'b0;
            r_fall_pend <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_brk       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit   <= 1'b0;
            r_par_err   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;

            if (w_restart) begin
                r_sample <= '0;
            end else if (w_state_next == ST_IDLE && r_state != ST_IDLE) begin
                r_sample <= '0;
            end else if (r_state == ST_IDLE) begin
                // After a break, r_sample counts consecutive high ticks instead.
                if (!r_brk_wait || (w_tick && !r_rx_sync)) r_sample <= '0;
                else if (w_tick) r_sample <= (r_sample == S_LAST) ? '0 : r_sample + 1'b1;
            end else if (w_tick) begin
                r_sample <= (r_sample == S_LAST) ? '0 : r_sample + 1'b1;
            end

            if (r_state == ST_IDLE && r_brk_wait && w_tick && r_rx_sync && r_sample == S_LAST)
                r_brk_wait <= 1'b0;

            if (w_state_next != r_state) r_bit_cnt <= '0;
            else if (w_bit_end)          r_bit_cnt <= r_bit_cnt + 1'b1;

            if (w_tick && r_sample == S_V0)  r_votes[0] <= r_rx_sync;
            if (w_tick && r_sample == S_MID) r_votes[1] <= r_rx_sync;

            if (w_tick && r_sample == S_V2) begin
                if (r_state == ST_DATA) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                if (r_state == ST_STOP && r_bit_cnt == 4'd0) r_stop_low <= !w_vote;
`ifdef UART_RX_PARITY_EN
                if (r_state == ST_PARITY) begin
                    r_par_bit <= w_vote;
                    r_par_err <= w_vote ^ (^r_shift) ^ (PARITY_ODD != 0);
                end
`endif
            end

            r_fall_pend <= (r_state == ST_STOP) &&
                           (r_fall_pend || (w_fall && r_bit_cnt == STOP_LAST && r_sample >= S_TAIL));

            if (w_state_next == ST_IDLE || w_state_next == ST_DONE) r_busy <= 1'b0;
            else if (w_start_ok) r_busy <= 1'b1;

            if (w_start_ok) begin
                r_err <= 1'b0;
                r_brk <= 1'b0;
`ifdef UART_RX_PARITY_EN
                r_par_err <= 1'b0;
`endif
            end

            if (r_state == ST_STOP && w_tick && !r_rx_sync &&
                r_sample >= S_WIN_LO && r_sample <= S_WIN_HI)
                r_err <= 1'b1;

            if (r_state == ST_STOP && w_state_next == ST_DONE) begin
                r_out  <= r_shift;
                r_done <= 1'b1;
`ifdef UART_RX_PARITY_EN
                if (r_shift == '0 && r_stop_low && !r_par_bit) begin
`else
                if (r_shift == '0 && r_stop_low) begin
`endif
                    r_brk      <= 1'b1;
                    r_err      <= 1'b1;
                    r_brk_wait <= 1'b1;
                end
            end
        end
    end

    assign rxBusy  = r_busy;
    assign rxDone  = r_done;
    assign rxErr   = r_err;
    assign rxBreak = r_brk;
    assign out     = r_out;
`ifdef UART_RX_PARITY_EN
    assign rxParErr = r_par_err;
`else
    assign rxParErr = 1'b0;
`endif

endmodule
